// File: rtl/instr_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_buf_pkg
//  Description : Shared types and default widths for the instruction
//                prefetch buffer. instr_entry_t is the {pc, instr} pair at
//                the default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_buf_pkg;

    localparam int IB_DATA_W = 32;
    localparam int IB_ADDR_W = 32;
    localparam int IB_DEPTH  = 4;

    typedef struct packed {
        logic [IB_ADDR_W-1:0] pc;
        logic [IB_DATA_W-1:0] instr;
    } instr_entry_t;

endpackage : instr_buf_pkg
`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_prefetch_buffer
//  Description : DEPTH-entry first-word-fall-through FIFO of {pc, instr}
//                pairs between fetch and decode, valid/ready on both sides,
//                with a flush that discards every queued entry.
//  Ports       : clk, reset (sync, active-high)
//                flush                          - drop all entries
//                in_valid/in_ready/in_instr/in_pc     - fetch side
//                out_valid/out_ready/out_instr/out_pc - decode side
//                count                          - occupied entries 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_buffer
    import instr_buf_pkg::*;
#(
    parameter int DATA_W = IB_DATA_W,
    parameter int ADDR_W = IB_ADDR_W,
    parameter int DEPTH  = IB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_instr,
    input  logic [ADDR_W-1:0]          in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("instr_prefetch_buffer: DEPTH must be a power of two >= 2");
        end
    endgenerate

    // Same layout as instr_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_not_empty;
    entry_t               w_head;

    // in_ready looks only at state and flush, so a pop cannot open a slot
    // for a push in the same cycle.
    assign w_not_empty = (r_count != '0);
    assign in_ready    = (r_count != c_FULL) & ~flush;
    assign out_valid   = w_not_empty;
    assign w_push      = in_valid & in_ready;
    assign w_pop       = w_not_empty & out_ready;

    assign w_head    = r_mem[r_rd_ptr];
    assign out_instr = w_not_empty ? w_head.instr : '0;
    assign out_pc    = w_not_empty ? w_head.pc    : '0;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            // A pop coinciding with flush is void; in_ready already blocks push.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{pc: in_pc, instr: in_instr};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_full : assert property (@(posedge clk) disable iff (reset)
        !(w_push && (r_count == c_FULL)));
    a_count_bounded : assert property (@(posedge clk) disable iff (reset)
        (r_count <= c_FULL));
`endif

endmodule : instr_prefetch_buffer
`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_prefetch_buffer
//  Description : Self-checking bench for instr_prefetch_buffer. A queue model
//                tracks the expected contents; directed scenarios plus a
//                randomized phase, with literal expectations pinning the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_buffer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr = '0;
    logic [ADDR_W-1:0] in_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [CNT_W-1:0]  count;

    instr_prefetch_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: queue of {pc, instr}, head at index 0.
    logic [ADDR_W+DATA_W-1:0] m_q[$];

    always @(posedge clk) begin
        if (reset || flush) begin
            m_q.delete();
        end else begin
            bit push_ok;
            bit pop_ok;
            push_ok = in_valid && (m_q.size() != DEPTH);
            pop_ok  = out_ready && (m_q.size() != 0);
            if (pop_ok)  void'(m_q.pop_front());
            if (push_ok) m_q.push_back({in_pc, in_instr});
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [ADDR_W+DATA_W-1:0] head;
            head = (m_q.size() != 0) ? m_q[0] : '0;
            chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
            chk("in_ready",  64'(in_ready),  64'((m_q.size() != DEPTH) && !flush));
            chk("count",     64'(count),     64'(m_q.size()));
            chk("out_instr", 64'(out_instr), 64'(head[DATA_W-1:0]));
            chk("out_pc",    64'(out_pc),    64'(head[ADDR_W+DATA_W-1:DATA_W]));
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic rs);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        #1;
    endtask

    initial begin
        logic [31:0] exp_heads [4];
        exp_heads[0] = 32'h22; exp_heads[1] = 32'h33;
        exp_heads[2] = 32'h44; exp_heads[3] = 32'h00;

        // 1: reset while fetch offers an instruction
        drive(1, 32'hDEADBEEF, 32'h0, 0, 0, 1);
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        chk_en = 1'b1;
        chk("t1 count",     64'(count),     64'd0);
        chk("t1 out_valid", 64'(out_valid), 64'd0);
        chk("t1 out_instr", 64'(out_instr), 64'd0);
        chk("t1 in_ready",  64'(in_ready),  64'd1);

        // 2: fill, then offer a 5th push
        for (int i = 0; i < 4; i++)
            drive(1, 32'h11 * (i + 1), 32'(4 * i), 0, 0, 0);
        drive(1, 32'h55, 32'h10, 0, 0, 0);
        chk("t2 count",     64'(count),     64'd4);
        chk("t2 in_ready",  64'(in_ready),  64'd0);
        chk("t2 out_instr", 64'(out_instr), 64'h11);
        chk("t2 out_pc",    64'(out_pc),    64'h0);

        // 3: drain four, in order
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        chk("t3 head0",  64'(out_instr), 64'h11);
        chk("t3 count0", 64'(count),     64'd4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 32'h0, 1, 0, 0);
            chk("t3 head",  64'(out_instr), 64'(exp_heads[i]));
            chk("t3 count", 64'(count),     64'(3 - i));
        end
        chk("t3 out_valid", 64'(out_valid), 64'd0);

        // 4: streaming push+pop for 10 entries
        drive(1, 32'h100, 32'h1000, 1, 0, 0);
        for (int i = 1; i < 10; i++) begin
            drive(1, 32'h100 + 32'(i), 32'h1000 + 32'(4 * i), 1, 0, 0);
            chk("t4 count", 64'(count),     64'd1);
            chk("t4 head",  64'(out_instr), 64'(32'h100 + 32'(i - 1)));
        end
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        chk("t4 last", 64'(out_instr), 64'h109);
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        chk("t4 empty", 64'(count), 64'd0);

        // 5: flush with a simultaneous push and pop
        for (int i = 0; i < 3; i++)
            drive(1, 32'hA0 + 32'(i), 32'h200 + 32'(4 * i), 0, 0, 0);
        drive(1, 32'h99, 32'h300, 1, 1, 0);
        chk("t5 in_ready_flush", 64'(in_ready), 64'd0);
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        chk("t5 count",     64'(count),     64'd0);
        chk("t5 out_valid", 64'(out_valid), 64'd0);
        drive(0, 32'h0, 32'h0, 1, 0, 0);
        chk("t5 no 0x99", 64'(out_instr), 64'd0);

        // 6: full, pop with a push offered in the same cycle
        for (int i = 0; i < 4; i++)
            drive(1, 32'hC0 + 32'(i), 32'h400 + 32'(4 * i), 0, 0, 0);
        drive(1, 32'hAA, 32'h500, 1, 0, 0);
        chk("t6 in_ready_full", 64'(in_ready), 64'd0);
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        chk("t6 count",    64'(count),     64'd3);
        chk("t6 in_ready", 64'(in_ready),  64'd1);
        chk("t6 head",     64'(out_instr), 64'hC1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0),
                  1'($urandom_range(0, 250) == 0));
        end
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_instr_prefetch_buffer
`default_nettype wire
